shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-pass controller around the team's 8-bit combinational `shifter`.
- Accepts a logical shift command with an amount of 0..31 over a valid/ready handshake.
- Splits the amount into passes of at most 7 bits and runs one pass per clock through a single `shifter` instance.
- Returns the result over a second valid/ready handshake. It sits between the command source and any consumer that needs shifts wider than one `shifter` pass allows.

Parameters:
- DATA_W, 8, operand width; fixed by `shifter`, exposed for documentation only, not to be overridden.
- AMT_W, 5, shift amount width; maximum amount is 2^AMT_W-1 = 31.
- STEP_MAX, 7, largest amount per pass; equals `shifter` amount range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_data  in  8  operand.
- cmd_amt  in  5  total shift amount.
- cmd_left  in  1  1 = left shift, 0 = right shift.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  shifted operand.
- res_passes  out  3  number of `shifter` passes used (0..5).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock. Reset is asynchronous, active-low.
- Reset values: state=IDLE, data_q=0, rem_q=0, dir_q=0, pass_q=0, res_valid=0, res_data=0, res_passes=0, busy=0, cmd_ready=1 (combinational from IDLE).
- States: IDLE, SHIFT, DONE.
- Outputs are decoded from state:
  - cmd_ready=(state==IDLE).
  - res_valid=(state==DONE).
  - busy=(state!=IDLE).
  - res_data=data_q, res_passes=pass_q.
- IDLE: on cmd_valid&&cmd_ready, capture data_q=cmd_data, rem_q=cmd_amt, dir_q=cmd_left, pass_q=0.
  - Next state is DONE if cmd_amt==0, else SHIFT.
  - cmd_* inputs are ignored outside IDLE.
- SHIFT:
  - step = min(rem_q, 7).
  - data_q <= shifter(data_q, step, dir_q).
  - rem_q <= rem_q - step.
  - pass_q <= pass_q + 1.
  - If rem_q <= 7, go to DONE; otherwise stay in SHIFT.
- `shifter` hookup: the amount's MSB drives s0, the middle bit s1, the LSB s2; left_direction=dir_q.
- DONE: res_data and res_passes are held stable while res_ready=0. On res_ready=1, go to IDLE.
- No same-cycle result-to-command bypass: the next command is accepted at the earliest one cycle after result acceptance.
- Latency, counted from the accepting edge to res_valid high: 1 cycle for amt=0, else 1+ceil(amt/7) cycles.
- Shifts are logical: zero fill, bits shifted out are lost. Amounts of 8 or more still run every pass; latency is deterministic, and no early-out on zero data.
- Boundary cases:
  - amt=7 and amt=14 take exactly 1 and 2 passes.
  - amt=31 takes 5 passes: 7,7,7,7,3.
  - rem_q never underflows.
  - pass_q maximum is 5.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE with all reset values; the in-flight result is discarded.
- res_ready asserted with res_valid=0 has no effect.

Decomposition:
- Package `shift_pkg`:
  - state enum (IDLE/SHIFT/DONE, 2-bit encoding).
  - DATA_W, AMT_W, STEP_MAX constants.
  - PASS_W=3.
- Sub-module: exactly one existing `shifter` instance, combinational. The step-clamp and subtract logic stays inline.

Test Plan:
- Reset, then left, cmd_data=0x09, cmd_amt=1 -> res_data=0x12, res_passes=1, res_valid 2 cycles after accept.
- Left, 0x01, amt=7 -> 0x80, passes=1. Then right, 0x80, amt=9 -> 0x00, passes=2, with data_q=0x01 after the first pass.
- amt=0, data=0xA5 -> res_data=0xA5, passes=0, res_valid 1 cycle after accept. Then left, 0xFF, amt=31 -> 0x00, passes=5, latency 6.
- Backpressure: right, 0xF0, amt=4, hold res_ready=0 for 3 cycles -> res_data=0x0F stable, cmd_ready=0 throughout. res_ready=1 -> IDLE next cycle, cmd_ready=1.
- Drive cmd_valid with new operands during SHIFT/DONE -> ignored, and the result matches the first command only.
- Assert rst_n=0 asynchronously during the 3rd pass of amt=20 -> outputs go to reset values immediately. After release, a left 0x03, amt=2 command returns 0x0C.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared constants and state encoding for the multi-pass shift sequencer.
package shift_pkg;
    localparam int DATA_W   = 8;
    localparam int AMT_W    = 5;
    localparam int STEP_MAX = 7;
    localparam int PASS_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shifter.sv
// shifter: combinational 8-bit logical shifter, amount 0..7 given as s0 (MSB), s1, s2 (LSB).
module shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic              s0,
    input  logic              s1,
    input  logic              s2,
    input  logic              left_direction,
    output logic [DATA_W-1:0] data_out
);
    logic [2:0] amt;
    assign amt      = {s0, s1, s2};
    assign data_out = left_direction ? data_in << amt : data_in >> amt;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: splits a 0..31 logical shift into passes of at most 7 bits through one shifter.
module shift_sequencer
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [AMT_W-1:0]  cmd_amt,
    input  logic              cmd_left,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [PASS_W-1:0] res_passes,
    output logic              busy
);
    state_t              state, state_nxt;
    logic [DATA_W-1:0]   data_q, sh_out;
    logic [AMT_W-1:0]    rem_q;
    logic                dir_q;
    logic [PASS_W-1:0]   pass_q;
    logic [2:0]          step;
    logic                last_pass;

    assign last_pass = rem_q <= AMT_W'(STEP_MAX);
    assign step      = last_pass ? rem_q[2:0] : 3'(STEP_MAX);

    shifter u_shifter (
        .data_in        (data_q),
        .s0             (step[2]),
        .s1             (step[1]),
        .s2             (step[0]),
        .left_direction (dir_q),
        .data_out       (sh_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            rem_q  <= '0;
            dir_q  <= 1'b0;
            pass_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_valid) begin
                data_q <= cmd_data;
                rem_q  <= cmd_amt;
                dir_q  <= cmd_left;
                pass_q <= '0;
            end else if (state == SHIFT) begin
                data_q <= sh_out;
                rem_q  <= rem_q - AMT_W'(step);
                pass_q <= pass_q + PASS_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = (state == IDLE);
        res_valid = (state == DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (cmd_valid) state_nxt = (cmd_amt == '0) ? DONE : SHIFT;
            SHIFT:   if (last_pass) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign res_data   = data_q;
    assign res_passes = pass_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic [4:0] cmd_amt = 5'd0;
    logic       cmd_left = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [2:0] res_passes;
    logic       busy;
    int         n_cmp = 0;
    int         n_err = 0;

    shift_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_amt    (cmd_amt),
        .cmd_left   (cmd_left),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_passes (res_passes),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts edges from the accepting edge (inclusive) until res_valid is seen.
    task automatic run_cmd(input logic [7:0] d, input logic [4:0] a, input logic l, input bit consume,
                           output int lat, output logic [7:0] rd, output logic [2:0] rp);
        int w = 0;
        while (!cmd_ready && w < 20) begin tick(); w++; end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_data = d; cmd_amt = a; cmd_left = l; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 16) begin tick(); lat++; end
        if (!res_valid) begin
            n_cmp++; n_err++;
            $display("FAIL res_valid_timeout: res_valid=%0b required 1", res_valid);
        end
        rd = res_data;
        rp = res_passes;
        if (consume) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %0b want 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (res_data !== 8'h00) begin n_err++; $display("FAIL rst_res_data: got %h want 00", res_data); end
        n_cmp++; if (res_passes !== 3'd0) begin n_err++; $display("FAIL rst_res_passes: got %0d want 0", res_passes); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; logic [7:0] rd; logic [2:0] rp;
        run_cmd(8'h09, 5'd1, 1'b1, 1'b1, lat, rd, rp);
        n_cmp++; if (rd !== 8'h12) begin n_err++; $display("FAIL l1_data: got %h want 12", rd); end
        n_cmp++; if (rp !== 3'd1) begin n_err++; $display("FAIL l1_passes: got %0d want 1", rp); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL l1_latency: got %0d want 2", lat); end
        run_cmd(8'h01, 5'd7, 1'b1, 1'b1, lat, rd, rp);
        n_cmp++; if (rd !== 8'h80) begin n_err++; $display("FAIL l7_data: got %h want 80", rd); end
        n_cmp++; if (rp !== 3'd1) begin n_err++; $display("FAIL l7_passes: got %0d want 1", rp); end
        run_cmd(8'hFF, 5'd3, 1'b0, 1'b1, lat, rd, rp);
        n_cmp++; if (rd !== 8'h1F) begin n_err++; $display("FAIL r3_data: got %h want 1F", rd); end
    endtask

    task automatic test_multi_pass();
        cmd_data = 8'h80; cmd_amt = 5'd9; cmd_left = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_cmp++; if (res_data !== 8'h01) begin n_err++; $display("FAIL r9_pass1_data: got %h want 01", res_data); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL r9_pass1_valid: got %0b want 0", res_valid); end
        n_cmp++; if (res_passes !== 3'd1) begin n_err++; $display("FAIL r9_pass1_passes: got %0d want 1", res_passes); end
        tick();
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL r9_valid: got %0b want 1", res_valid); end
        n_cmp++; if (res_data !== 8'h00) begin n_err++; $display("FAIL r9_data: got %h want 00", res_data); end
        n_cmp++; if (res_passes !== 3'd2) begin n_err++; $display("FAIL r9_passes: got %0d want 2", res_passes); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_boundaries();
        int lat; logic [7:0] rd; logic [2:0] rp;
        run_cmd(8'hA5, 5'd0, 1'b1, 1'b1, lat, rd, rp);
        n_cmp++; if (rd !== 8'hA5) begin n_err++; $display("FAIL a0_data: got %h want A5", rd); end
        n_cmp++; if (rp !== 3'd0) begin n_err++; $display("FAIL a0_passes: got %0d want 0", rp); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL a0_latency: got %0d want 1", lat); end
        run_cmd(8'hFF, 5'd31, 1'b1, 1'b1, lat, rd, rp);
        n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL a31_data: got %h want 00", rd); end
        n_cmp++; if (rp !== 3'd5) begin n_err++; $display("FAIL a31_passes: got %0d want 5", rp); end
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL a31_latency: got %0d want 6", lat); end
        run_cmd(8'h01, 5'd14, 1'b1, 1'b1, lat, rd, rp);
        n_cmp++; if (rp !== 3'd2) begin n_err++; $display("FAIL a14_passes: got %0d want 2", rp); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL a14_latency: got %0d want 3", lat); end
    endtask

    task automatic test_backpressure();
        int lat; logic [7:0] rd; logic [2:0] rp;
        res_ready = 1'b1;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL idle_res_ready: cmd_ready=%0b busy=%0b want 1/0", cmd_ready, busy); end
        res_ready = 1'b0;
        run_cmd(8'hF0, 5'd4, 1'b0, 1'b0, lat, rd, rp);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (res_data !== 8'h0F || cmd_ready !== 1'b0 || res_valid !== 1'b1)
            begin n_err++; $display("FAIL bp_hold%0d: data=%h cmd_ready=%0b res_valid=%0b want 0F/0/1", i, res_data, cmd_ready, res_valid); end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: cmd_ready=%0b res_valid=%0b want 1/0", cmd_ready, res_valid); end
    endtask

    task automatic test_ignore_cmd();
        int w = 0;
        cmd_data = 8'h03; cmd_amt = 5'd5; cmd_left = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_data = 8'hFF; cmd_amt = 5'd0; cmd_left = 1'b0;
        while (!res_valid && w < 16) begin tick(); w++; end
        tick();
        n_cmp++; if (res_data !== 8'h60) begin n_err++; $display("FAIL ign_data: got %h want 60", res_data); end
        n_cmp++; if (res_passes !== 3'd1) begin n_err++; $display("FAIL ign_passes: got %0d want 1", res_passes); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL no_bypass: busy=%0b cmd_ready=%0b want 0/1", busy, cmd_ready); end
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int lat; logic [7:0] rd; logic [2:0] rp;
        cmd_data = 8'hFF; cmd_amt = 5'd20; cmd_left = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (res_passes !== 3'd2 || busy !== 1'b1) begin n_err++; $display("FAIL ar_progress: passes=%0d busy=%0b want 2/1", res_passes, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h00 || res_passes !== 3'd0)
        begin n_err++; $display("FAIL ar_values: busy=%0b cmd_ready=%0b res_valid=%0b data=%h passes=%0d want 0/1/0/00/0", busy, cmd_ready, res_valid, res_data, res_passes); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_cmd(8'h03, 5'd2, 1'b1, 1'b1, lat, rd, rp);
        n_cmp++; if (rd !== 8'h0C) begin n_err++; $display("FAIL ar_after_data: got %h want 0C", rd); end
        n_cmp++; if (rp !== 3'd1) begin n_err++; $display("FAIL ar_after_passes: got %0d want 1", rp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_pass();
        test_boundaries();
        test_backpressure();
        test_ignore_cmd();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
